// File: rtl/hyperbus_resp_pkg.sv
// Shared types and constants for the HyperRAM responder.
package hyperbus_resp_pkg;

  // Transaction phases of the responder
  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    WR,
    RD,
    REGWR,
    ABORT
  } state_e;

  // Bit positions inside the 48-bit command/address
  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  // Register-space word addresses
  localparam logic [31:0] REG_ID0 = 32'h0000_0000;
  localparam logic [31:0] REG_CR0 = 32'h0000_0800;

endpackage

// File: rtl/hyperbus_ram_responder_if.sv
// Word-level HyperBus link between controller (master) and responder (slave).
interface hyperbus_ram_responder_if;
  logic        cs_ni;
  logic [15:0] dq_i;
  logic        dq_valid_i;
  logic [1:0]  rwds_i;
  logic [15:0] dq_o;
  logic        dq_oe_o;
  logic        rwds_o;
  logic        rwds_oe_o;
  logic        busy_o;

  modport master (
    output cs_ni, dq_i, dq_valid_i, rwds_i,
    input  dq_o, dq_oe_o, rwds_o, rwds_oe_o, busy_o
  );

  modport slave (
    input  cs_ni, dq_i, dq_valid_i, rwds_i,
    output dq_o, dq_oe_o, rwds_o, rwds_oe_o, busy_o
  );
endinterface

// File: rtl/hyperbus_ram_array.sv
// Single-port synchronous RAM, 16-bit words, per-byte write enable,
// read data appears one cycle after the address.
module hyperbus_ram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [1:0]            be_i,
  input  logic [15:0]           wdata_i,
  output logic [15:0]           rdata_o
);

  logic [15:0] mem [2**ADDR_WIDTH];

  // Byte-masked write and registered read on the same address
  always_ff @(posedge clk_i) begin
    if (we_i && be_i[1]) mem[addr_i][15:8] <= wdata_i[15:8];
    if (we_i && be_i[0]) mem[addr_i][7:0]  <= wdata_i[7:0];
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/hyperbus_ram_responder.sv
// Device-side HyperRAM responder: decodes the 48-bit CA, applies fixed
// double latency and serves memory/register accesses at word level.
module hyperbus_ram_responder
  import hyperbus_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 6,
  parameter int          WRAP_WORDS = 16,
  parameter logic [15:0] ID0_VAL    = 16'h0C81,
  parameter logic [15:0] CR0_RST    = 16'h8F1F
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  hyperbus_ram_responder_if.slave  bus
);

  localparam int         WRAP_BITS = $clog2(WRAP_WORDS);
  localparam logic [7:0] LAT_LOAD  = 8'(2*LATENCY-1);

  state_e      state_q;
  logic [1:0]  caCnt_q;
  logic [15:0] caW0_q, caW1_q;
  logic        isRead_q, isReg_q, isLinear_q;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  latCnt_q;
  logic [15:0] cr0_q, regData_q, regData_d;
  logic        dqOe_q, rwds_q, rwdsOe_q;
  logic [31:0] caAddr;
  logic        ramWe;
  logic [15:0] ramRdata;
  logic        dqOe;

  // Word address assembled from the two held CA words and the one on the bus
  assign caAddr = {caW0_q[12:0], caW1_q, bus.dq_i[2:0]};

  // Next burst address: linear wraps over the array, wrapped stays in its block
  always_comb begin
    addr_d = addr_q;
    if (isLinear_q) addr_d[ADDR_WIDTH-1:0] = addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
    else            addr_d[WRAP_BITS-1:0]  = addr_q[WRAP_BITS-1:0] + WRAP_BITS'(1);
  end

  // Register-space read value for the address currently being issued
  always_comb begin
    regData_d = '0;
    if (addr_q == REG_ID0)      regData_d = ID0_VAL;
    else if (addr_q == REG_CR0) regData_d = cr0_q;
  end

  assign ramWe = (state_q == WR) && bus.dq_valid_i && !bus.cs_ni;

  hyperbus_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk_i   (clk_i),
    .addr_i  (addr_q[ADDR_WIDTH-1:0]),
    .we_i    (ramWe),
    .be_i    (~bus.rwds_i),
    .wdata_i (bus.dq_i),
    .rdata_o (ramRdata)
  );

  // Transaction FSM with registered output enables; chip select aborts anything
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      caCnt_q    <= '0;
      caW0_q     <= '0;
      caW1_q     <= '0;
      isRead_q   <= 1'b0;
      isReg_q    <= 1'b0;
      isLinear_q <= 1'b0;
      addr_q     <= '0;
      latCnt_q   <= '0;
      cr0_q      <= CR0_RST;
      regData_q  <= '0;
      dqOe_q     <= 1'b0;
      rwds_q     <= 1'b0;
      rwdsOe_q   <= 1'b0;
    end else if (bus.cs_ni) begin
      state_q  <= IDLE;
      dqOe_q   <= 1'b0;
      rwds_q   <= 1'b0;
      rwdsOe_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.dq_valid_i) begin
            caW0_q   <= bus.dq_i;
            caCnt_q  <= 2'd1;
            state_q  <= CA;
            rwdsOe_q <= 1'b1;
            rwds_q   <= 1'b1;
          end
        end
        CA: begin
          if (bus.dq_valid_i) begin
            if (caCnt_q == 2'd1) begin
              caW1_q  <= bus.dq_i;
              caCnt_q <= 2'd2;
            end else begin
              isRead_q   <= caW0_q[CA_RW-32];
              isReg_q    <= caW0_q[CA_AS-32];
              isLinear_q <= caW0_q[CA_BT-32];
              addr_q     <= caAddr;
              rwdsOe_q   <= 1'b0;
              rwds_q     <= 1'b0;
              if (!caW0_q[CA_RW-32] && caW0_q[CA_AS-32]) begin
                state_q <= REGWR;
              end else begin
                state_q  <= LAT;
                latCnt_q <= LAT_LOAD;
              end
            end
          end
        end
        LAT: begin
          if (latCnt_q == 8'd0) begin
            if (isRead_q) begin
              state_q   <= RD;
              dqOe_q    <= 1'b1;
              rwdsOe_q  <= 1'b1;
              rwds_q    <= 1'b1;
              addr_q    <= addr_d;
              regData_q <= regData_d;
            end else begin
              state_q <= WR;
            end
          end else begin
            latCnt_q <= latCnt_q - 8'd1;
          end
        end
        WR: begin
          if (bus.dq_valid_i) addr_q <= addr_d;
        end
        RD: begin
          addr_q    <= addr_d;
          regData_q <= regData_d;
        end
        REGWR: begin
          if (bus.dq_valid_i) begin
            if (addr_q == REG_CR0) cr0_q <= bus.dq_i;
            state_q <= ABORT;
          end
        end
        ABORT:   state_q <= ABORT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dqOe          = dqOe_q && !bus.cs_ni;
  assign bus.dq_oe_o   = dqOe;
  assign bus.dq_o      = dqOe ? (isReg_q ? regData_q : ramRdata) : 16'h0000;
  assign bus.rwds_o    = rwds_q && !bus.cs_ni;
  assign bus.rwds_oe_o = rwdsOe_q && !bus.cs_ni;
  assign bus.busy_o    = (state_q != IDLE) && !bus.cs_ni;

endmodule

// File: doc/hyperbus_ram_responder.md
Name: hyperbus_ram_responder

Overview:
Device-side HyperRAM responder: the far end of the HyperBus link driven by the hyperbus controller.
- Operates at word level: one 16-bit DDR word pair per clk_i cycle.
- Decodes the 48-bit command/address, applies fixed double latency, and serves memory and register reads/writes from an internal array.
- Used as a synthesizable memory model for FPGA emulation and for controller verification.

Parameters:
ADDR_WIDTH, 10, word-address bits of the internal array (1024 x 16 bit).
LATENCY, 6, initial latency in CK cycles; the wait phase is always 2*LATENCY cycles (fixed double latency).
WRAP_WORDS, 16, wrapped-burst length in words; must be a power of two.
ID0_VAL, 16'h0C81, value returned for register address 0x0000.
CR0_RST, 16'h8F1F, reset value of CR0.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
cs_ni  in  1  chip select, active low
dq_i  in  16  CA word or write data; bits [15:8] are the first byte on the wire
dq_valid_i  in  1  controller drives a valid word on dq_i this cycle
rwds_i  in  2  write byte mask per byte; 1 = byte masked (not written)
dq_o  out  16  read data word
dq_oe_o  out  1  responder drives DQ
rwds_o  out  1  RWDS level
rwds_oe_o  out  1  responder drives RWDS
busy_o  out  1  transaction in progress (state not IDLE)

Behaviour:
Reset: all outputs are 0, state is IDLE, CR0 = CR0_RST. Array contents are not reset.

States: IDLE, CA, LAT, WR, RD, REGWR, ABORT.

Any cycle with cs_ni=1:
- Next state is IDLE.
- Outputs are deasserted in that same cycle (combinational gating by cs_ni).
- Any word not already written is discarded.

IDLE -> CA:
- Triggered by cs_ni=0 with dq_valid_i=1; that word is CA[47:32].
- CA captures CA[31:16] and CA[15:0] on the next two valid words. Cycles with dq_valid_i=0 are held and not counted.
- During CA: rwds_oe_o=1 and rwds_o=1, signalling double latency.

CA field decode:
- CA[47]: 1 = read.
- CA[46]: 1 = register space.
- CA[45]: 1 = linear burst, 0 = wrapped burst.
- Word address = {CA[44:16], CA[2:0]}; memory space uses the low ADDR_WIDTH bits.

Cycle n is the cycle in which the third CA word is sampled. Transitions from cycle n:
- Register write goes to REGWR. The word with dq_valid_i=1 at n+1 or later is written to CR0 only if the address is 0x800, otherwise dropped. The next state is then ABORT. No latency is applied.
- All other commands go to LAT. The counter is loaded with 2*LATENCY-1 and decrements to 0 over cycles n+1 .. n+2*LATENCY.
- LAT exits to RD or WR.

WR:
- Entered at n+2*LATENCY+1.
- Each cycle with dq_valid_i=1 writes dq_i to the current address with byte enables ~rwds_i, then advances the address.
- dq_valid_i=1 during LAT is ignored.

RD:
- Array read address is issued in the last LAT cycle.
- dq_oe_o=1 and rwds_oe_o=1 from n+2*LATENCY+1 while cs_ni=0.
- rwds_o=1 on every cycle in which dq_o carries a valid word; there is no gap between words.
- The address advances every cycle.
- dq_valid_i=1 in RD is ignored.
- Register read data: address 0x000 returns ID0_VAL, 0x800 returns CR0, any other address returns 0.

Address increment:
- Linear: +1, wrapping modulo 2^ADDR_WIDTH.
- Wrapped: the low log2(WRAP_WORDS) bits increment modulo WRAP_WORDS; upper bits are fixed.

ABORT: waits for cs_ni=1 and ignores all inputs.

Other rules:
- CR0 is storage only; it does not alter the latency or wrap behaviour.
- Reset asserted mid-transaction: IDLE immediately, outputs 0. A write in progress keeps the words already committed.

Decomposition:
- Package hyperbus_resp_pkg:
  - state enum;
  - CA bit-position localparams (CA_RW=47, CA_AS=46, CA_BT=45);
  - register addresses (REG_ID0=0x000, REG_CR0=0x800).
- Sub-module hyperbus_ram_array: single-port synchronous RAM, 2^ADDR_WIDTH x 16, 2-bit byte-write enable, 1-cycle read latency.

Test Plan:
1. Linear write then read:
   - Write 4 words 0x1111..0x4444 at address 0x10, LATENCY=6.
   - Linear read of 4 words from 0x10: first rwds_o=1 exactly at n+13, data 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles.
2. Wrapped read:
   - Preload address k with value k, k = 0x10..0x1F.
   - Wrapped read of 4 words from 0x1E returns 0x1E, 0x1F, 0x10, 0x11.
3. Byte mask:
   - Write 0xABCD with rwds_i=2'b01 over 0x0000 at address 5.
   - Read address 5 returns 0xAB00.
4. Abort:
   - Write to address 0x20 with cs_ni raised at n+3, mid-LAT; later read of 0x20 returns the preloaded value unchanged.
   - busy_o=0 in the cycle after cs_ni rises.
5. Register space:
   - Register read of 0x000 returns 0x0C81.
   - Register write of 0x8F17 to 0x800 at n+1; register read of 0x800 then returns 0x8F17.
   - After rst_i, the register read of 0x800 returns 0x8F1F.
6. Reset mid-read:
   - Assert rst_i during the second RD word: dq_oe_o, rwds_oe_o and busy_o are 0 in the same cycle.
   - The next transaction after reset completes normally.
